// File: rtl/axi_pkg.sv
// Shared burst encodings, engine state enums and the burst next-index function
// used by the AXI memory responder.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Illegal WRAP lengths and the reserved encoding fall back to INCR.
    function automatic logic [31:0] next_idx(input logic [31:0] idx,
                                             input logic [1:0]  burst,
                                             input logic [7:0]  len);
        logic [31:0] mask;
        logic [31:0] res;
        mask = {24'd0, len};
        case (burst)
            BURST_FIXED: res = idx;
            BURST_WRAP: begin
                if (wrap_len_ok(len)) begin
                    res = (idx & ~mask) | ((idx + 32'd1) & mask);
                end else begin
                    res = idx + 32'd1;
                end
            end
            default: res = idx + 32'd1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-word-index generator for one burst engine, plus detection
// of reserved bursts, illegal WRAP lengths and non-full-width beat sizes.
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int         IDX_W     = 16,
    parameter logic [2:0] FULL_SIZE = 3'd4
) (
    input  logic [IDX_W-1:0] idx_i,
    input  logic [1:0]       burst_i,
    input  logic [7:0]       len_i,
    input  logic [2:0]       size_i,
    output logic [IDX_W-1:0] next_idx_o,
    output logic             err_o
);

    logic burst_rsvd_s;
    logic wrap_bad_s;
    logic size_bad_s;

    assign next_idx_o   = IDX_W'(next_idx(32'(idx_i), burst_i, len_i));
    assign burst_rsvd_s = (burst_i == 2'b11);
    assign wrap_bad_s   = (burst_i == BURST_WRAP) && !wrap_len_ok(len_i);
    assign size_bad_s   = (size_i != FULL_SIZE);
    assign err_o        = burst_rsvd_s | wrap_bad_s | size_bad_s;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by a word array: independent read and write burst engines
// sharing one write port and one read port, with a sticky protocol-error flag.
module axi_mem_responder
    import axi_pkg::*;
#(
    parameter int WIDTH       = 128,
    parameter int ID_LEN      = 2,
    parameter int ADDR_LEN    = 32,
    parameter int MEM_WORDS_E = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_LEN-1:0]   s_axi_awid,
    input  logic [ADDR_LEN-1:0] s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awlock,
    input  logic [3:0]          s_axi_awcache,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [WIDTH-1:0]    s_axi_wdata,
    input  logic [WIDTH/8-1:0]  s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    input  logic                s_axi_bready,
    output logic [ID_LEN-1:0]   s_axi_bid,
    output logic                s_axi_bvalid,
    input  logic [ID_LEN-1:0]   s_axi_arid,
    input  logic [ADDR_LEN-1:0] s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arlock,
    input  logic [3:0]          s_axi_arcache,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    input  logic                s_axi_rready,
    output logic [ID_LEN-1:0]   s_axi_rid,
    output logic [WIDTH-1:0]    s_axi_rdata,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    output logic                OUT_protoErr
);

    localparam int         STRB_W    = WIDTH / 8;
    localparam int         BYTE_OFF  = $clog2(STRB_W);
    localparam int         MEM_DEPTH = 2 ** MEM_WORDS_E;
    localparam logic [2:0] FULL_SIZE = 3'(BYTE_OFF);

    logic [WIDTH-1:0] mem_q [MEM_DEPTH];

    w_state_e               w_state_q, w_state_d;
    logic [ID_LEN-1:0]      w_id_q, w_id_d;
    logic [MEM_WORDS_E-1:0] w_idx_q, w_idx_d, w_next_idx_s;
    logic [7:0]             w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [1:0]             w_burst_q, w_burst_d;
    logic [2:0]             w_size_q, w_size_d;
    logic                   w_addr_err_s, w_hs_s, w_last_beat_s;

    r_state_e               r_state_q, r_state_d;
    logic [ID_LEN-1:0]      r_id_q, r_id_d;
    logic [MEM_WORDS_E-1:0] r_idx_q, r_idx_d, r_next_idx_s, rd_idx_s;
    logic [7:0]             r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [1:0]             r_burst_q, r_burst_d;
    logic [2:0]             r_size_q, r_size_d;
    logic                   r_rlast_q, r_rlast_d;
    logic [WIDTH-1:0]       r_rdata_q;
    logic                   r_addr_err_s, r_hs_s, r_last_beat_s, rd_en_s;

    logic err_q, err_d;
    logic unused_s;

    assign unused_s = ^{s_axi_awlock, s_axi_awcache, s_axi_arlock, s_axi_arcache,
                        s_axi_awaddr, s_axi_araddr};

    axi_burst_addr #(.IDX_W(MEM_WORDS_E), .FULL_SIZE(FULL_SIZE)) u_w_addr (
        .idx_i      (w_idx_q),
        .burst_i    (w_burst_q),
        .len_i      (w_len_q),
        .size_i     (w_size_q),
        .next_idx_o (w_next_idx_s),
        .err_o      (w_addr_err_s)
    );

    axi_burst_addr #(.IDX_W(MEM_WORDS_E), .FULL_SIZE(FULL_SIZE)) u_r_addr (
        .idx_i      (r_idx_q),
        .burst_i    (r_burst_q),
        .len_i      (r_len_q),
        .size_i     (r_size_q),
        .next_idx_o (r_next_idx_s),
        .err_o      (r_addr_err_s)
    );

    assign w_hs_s        = (w_state_q == W_DATA) && s_axi_wvalid;
    assign w_last_beat_s = (w_cnt_q == w_len_q);
    assign r_hs_s        = (r_state_q == R_DATA) && s_axi_rready;
    assign r_last_beat_s = (r_cnt_q == r_len_q);

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_burst_d = w_burst_q;
        w_size_d  = w_size_q;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi_awvalid) begin
                    w_id_d    = s_axi_awid;
                    w_idx_d   = s_axi_awaddr[BYTE_OFF +: MEM_WORDS_E];
                    w_len_d   = s_axi_awlen;
                    w_burst_d = s_axi_awburst;
                    w_size_d  = s_axi_awsize;
                    w_cnt_d   = 8'd0;
                    w_state_d = W_DATA;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid) begin
                    w_idx_d = w_next_idx_s;
                    w_cnt_d = w_cnt_q + 8'd1;
                    if (w_last_beat_s) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_state_d = W_DATA;
                    end
                end else begin
                    w_state_d = W_DATA;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_burst_d = r_burst_q;
        r_size_d  = r_size_q;
        r_rlast_d = r_rlast_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid) begin
                    r_id_d    = s_axi_arid;
                    r_idx_d   = s_axi_araddr[BYTE_OFF +: MEM_WORDS_E];
                    r_len_d   = s_axi_arlen;
                    r_burst_d = s_axi_arburst;
                    r_size_d  = s_axi_arsize;
                    r_cnt_d   = 8'd0;
                    r_rlast_d = (s_axi_arlen == 8'd0);
                    r_state_d = R_DATA;
                end else begin
                    r_rlast_d = 1'b0;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    if (r_last_beat_s) begin
                        r_rlast_d = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d   = r_next_idx_s;
                        r_cnt_d   = r_cnt_q + 8'd1;
                        r_rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
                    end
                end else begin
                    r_rlast_d = r_rlast_q;
                end
            end
            default: begin
                r_rlast_d = 1'b0;
                r_state_d = R_IDLE;
            end
        endcase
    end

    // The read register is loaded on the request itself and on each non-final
    // accepted beat, so the next word is already in place for streaming.
    assign rd_idx_s = (r_state_q == R_IDLE) ? s_axi_araddr[BYTE_OFF +: MEM_WORDS_E]
                                            : r_next_idx_s;
    assign rd_en_s  = ((r_state_q == R_IDLE) && s_axi_arvalid) || (r_hs_s && !r_last_beat_s);

    assign err_d = err_q
                 | ((w_state_q == W_DATA) && w_addr_err_s)
                 | (w_hs_s && (s_axi_wlast != w_last_beat_s))
                 | ((r_state_q == R_DATA) && r_addr_err_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_len_q   <= 8'd0;
            w_cnt_q   <= 8'd0;
            w_burst_q <= BURST_INCR;
            w_size_q  <= FULL_SIZE;
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_len_q   <= 8'd0;
            r_cnt_q   <= 8'd0;
            r_burst_q <= BURST_INCR;
            r_size_q  <= FULL_SIZE;
            r_rlast_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_burst_q <= w_burst_d;
            w_size_q  <= w_size_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_burst_q <= r_burst_d;
            r_size_q  <= r_size_d;
            r_rlast_q <= r_rlast_d;
            err_q     <= err_d;
        end
    end

    // Read port; a same-edge write to this word is not yet visible (old data).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata_q <= '0;
        end else if (rd_en_s) begin
            r_rdata_q <= mem_q[rd_idx_s];
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem_q[w_idx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign s_axi_awready = (w_state_q == W_IDLE);
    assign s_axi_wready  = (w_state_q == W_DATA);
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_bid     = w_id_q;
    assign s_axi_arready = (r_state_q == R_IDLE);
    assign s_axi_rvalid  = (r_state_q == R_DATA);
    assign s_axi_rid     = r_id_q;
    assign s_axi_rdata   = r_rdata_q;
    assign s_axi_rlast   = r_rlast_q;
    assign OUT_protoErr  = err_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder: reset state, single and
// burst transfers, WRAP, strobes, read backpressure, protocol error, mid-burst reset.
module tb_axi_mem_responder;

    logic         clk;
    logic         rst;
    logic [1:0]   s_axi_awid;
    logic [31:0]  s_axi_awaddr;
    logic [7:0]   s_axi_awlen;
    logic [2:0]   s_axi_awsize;
    logic [1:0]   s_axi_awburst;
    logic         s_axi_awlock;
    logic [3:0]   s_axi_awcache;
    logic         s_axi_awvalid;
    logic         s_axi_awready;
    logic [127:0] s_axi_wdata;
    logic [15:0]  s_axi_wstrb;
    logic         s_axi_wlast;
    logic         s_axi_wvalid;
    logic         s_axi_wready;
    logic         s_axi_bready;
    logic [1:0]   s_axi_bid;
    logic         s_axi_bvalid;
    logic [1:0]   s_axi_arid;
    logic [31:0]  s_axi_araddr;
    logic [7:0]   s_axi_arlen;
    logic [2:0]   s_axi_arsize;
    logic [1:0]   s_axi_arburst;
    logic         s_axi_arlock;
    logic [3:0]   s_axi_arcache;
    logic         s_axi_arvalid;
    logic         s_axi_arready;
    logic         s_axi_rready;
    logic [1:0]   s_axi_rid;
    logic [127:0] s_axi_rdata;
    logic         s_axi_rlast;
    logic         s_axi_rvalid;
    logic         OUT_protoErr;

    int total_s;
    int bad_s;
    logic [127:0] vec_s [16];

    localparam logic [127:0] WORD_D1 = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_DEAD_BEEF;
    localparam logic [127:0] WORD_A  = 128'hAAAA_0000_1111_2222_3333_4444_5555_000A;
    localparam logic [127:0] WORD_B  = 128'hBBBB_0000_1111_2222_3333_4444_5555_000B;
    localparam logic [127:0] WORD_C  = 128'hCCCC_0000_1111_2222_3333_4444_5555_000C;
    localparam logic [127:0] WORD_D  = 128'hDDDD_0000_1111_2222_3333_4444_5555_000D;
    localparam logic [127:0] WORD_X  = 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;
    localparam logic [127:0] WORD_Y  = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;

    axi_mem_responder dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awsize  (s_axi_awsize),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awlock  (s_axi_awlock),
        .s_axi_awcache (s_axi_awcache),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bready  (s_axi_bready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arlock  (s_axi_arlock),
        .s_axi_arcache (s_axi_arcache),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .OUT_protoErr  (OUT_protoErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_s++;
        if (obs !== exp) begin
            bad_s++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic do_aw(input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [1:0] id);
        int n;
        s_axi_awaddr  = addr;
        s_axi_awlen   = len;
        s_axi_awburst = burst;
        s_axi_awid    = id;
        s_axi_awvalid = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check_val("awready", s_axi_awready, 1'b1);
        @(negedge clk);
        s_axi_awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [127:0] data, input logic [15:0] strb, input logic last);
        int n;
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        s_axi_wlast  = last;
        s_axi_wvalid = 1'b1;
        n = 0;
        while (!s_axi_wready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check_val("wready", s_axi_wready, 1'b1);
        @(negedge clk);
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
    endtask

    task automatic do_b(input logic [1:0] id);
        check_val("bvalid", s_axi_bvalid, 1'b1);
        check_val("bid", s_axi_bid, id);
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        check_val("b_done", s_axi_bvalid, 1'b0);
    endtask

    task automatic wr_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [1:0] id, input logic [15:0] strb);
        do_aw(addr, len, burst, id);
        for (int k = 0; k <= int'(len); k++) begin
            do_w(vec_s[k], strb, (k == int'(len)));
        end
        do_b(id);
    endtask

    task automatic do_ar(input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [1:0] id);
        int n;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arburst = burst;
        s_axi_arid    = id;
        s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check_val("arready", s_axi_arready, 1'b1);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
    endtask

    task automatic rd_burst(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [1:0] id);
        do_ar(addr, len, burst, id);
        s_axi_rready = 1'b1;
        for (int k = 0; k <= int'(len); k++) begin
            check_val("rvalid", s_axi_rvalid, 1'b1);
            check_val("rdata", s_axi_rdata, vec_s[k]);
            check_val("rlast", s_axi_rlast, (k == int'(len)));
            check_val("rid", s_axi_rid, id);
            @(negedge clk);
        end
        s_axi_rready = 1'b0;
        check_val("r_done", s_axi_rvalid, 1'b0);
    endtask

    initial begin
        logic [3:0] rr_pat;
        int beats;
        total_s = 0;
        bad_s   = 0;
        rst = 1'b1;
        s_axi_awid = 2'd0;   s_axi_awaddr = 32'd0; s_axi_awlen = 8'd0; s_axi_awsize = 3'd4;
        s_axi_awburst = 2'b01; s_axi_awlock = 1'b0; s_axi_awcache = 4'd0; s_axi_awvalid = 1'b0;
        s_axi_wdata = 128'd0; s_axi_wstrb = 16'd0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_arid = 2'd0;   s_axi_araddr = 32'd0; s_axi_arlen = 8'd0; s_axi_arsize = 3'd4;
        s_axi_arburst = 2'b01; s_axi_arlock = 1'b0; s_axi_arcache = 4'd0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_val("rst_awready", s_axi_awready, 1'b1);
        check_val("rst_arready", s_axi_arready, 1'b1);
        check_val("rst_wready", s_axi_wready, 1'b0);
        check_val("rst_bvalid", s_axi_bvalid, 1'b0);
        check_val("rst_rvalid", s_axi_rvalid, 1'b0);
        check_val("rst_rlast", s_axi_rlast, 1'b0);
        check_val("rst_err", OUT_protoErr, 1'b0);
        check_val("rst_bid", s_axi_bid, 2'd0);
        check_val("rst_rid", s_axi_rid, 2'd0);
        check_val("rst_rdata", s_axi_rdata, 128'd0);

        vec_s[0] = WORD_D1;
        wr_burst(32'h0000_0100, 8'd0, 2'b01, 2'd2, 16'hFFFF);
        rd_burst(32'h0000_0100, 8'd0, 2'b01, 2'd1);

        for (int k = 0; k < 4; k++) vec_s[k] = 128'(k);
        wr_burst(32'h0000_0200, 8'd3, 2'b01, 2'd3, 16'hFFFF);
        rd_burst(32'h0000_0200, 8'd3, 2'b01, 2'd0);

        vec_s[0] = WORD_A; vec_s[1] = WORD_B; vec_s[2] = WORD_C; vec_s[3] = WORD_D;
        wr_burst(32'h0000_0200, 8'd3, 2'b01, 2'd1, 16'hFFFF);
        vec_s[0] = WORD_D; vec_s[1] = WORD_A; vec_s[2] = WORD_B; vec_s[3] = WORD_C;
        rd_burst(32'h0000_0230, 8'd3, 2'b10, 2'd2);
        check_val("wrap_err", OUT_protoErr, 1'b0);

        vec_s[0] = {128{1'b1}};
        wr_burst(32'h0000_0300, 8'd0, 2'b01, 2'd0, 16'hFFFF);
        vec_s[0] = 128'd0;
        wr_burst(32'h0000_0300, 8'd0, 2'b01, 2'd0, 16'h000F);
        vec_s[0] = {{96{1'b1}}, 32'h0000_0000};
        rd_burst(32'h0000_0300, 8'd0, 2'b01, 2'd0);

        do_ar(32'h0000_0200, 8'd1, 2'b01, 2'd3);
        rr_pat = 4'b1001;
        beats = 0;
        for (int c = 0; c < 4; c++) begin
            s_axi_rready = rr_pat[c];
            check_val("bp_rvalid", s_axi_rvalid, 1'b1);
            check_val("bp_rdata", s_axi_rdata, (c == 0) ? WORD_A : WORD_B);
            check_val("bp_rlast", s_axi_rlast, (c != 0));
            check_val("bp_rid", s_axi_rid, 2'd3);
            if (s_axi_rvalid && s_axi_rready) beats++;
            @(negedge clk);
        end
        s_axi_rready = 1'b0;
        check_val("bp_end", s_axi_rvalid, 1'b0);
        check_val("bp_beats", 128'(beats), 128'd2);
        check_val("pre_err", OUT_protoErr, 1'b0);

        do_aw(32'h0000_0400, 8'd1, 2'b01, 2'd1);
        do_w(WORD_X, 16'hFFFF, 1'b1);
        do_w(WORD_Y, 16'hFFFF, 1'b1);
        check_val("wlast_err", OUT_protoErr, 1'b1);
        do_b(2'd1);
        vec_s[0] = WORD_X; vec_s[1] = WORD_Y;
        rd_burst(32'h0000_0400, 8'd1, 2'b01, 2'd0);

        do_ar(32'h0000_0200, 8'd3, 2'b01, 2'd2);
        s_axi_rready = 1'b1;
        check_val("mid_rdata0", s_axi_rdata, WORD_A);
        @(negedge clk);
        check_val("mid_rdata1", s_axi_rdata, WORD_B);
        rst = 1'b1;
        #1;
        check_val("mrst_rvalid", s_axi_rvalid, 1'b0);
        check_val("mrst_arready", s_axi_arready, 1'b1);
        check_val("mrst_rlast", s_axi_rlast, 1'b0);
        check_val("mrst_rdata", s_axi_rdata, 128'd0);
        check_val("mrst_err", OUT_protoErr, 1'b0);
        s_axi_rready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vec_s[0] = WORD_D1;
        rd_burst(32'h0000_0100, 8'd0, 2'b01, 2'd1);

        $display("test done: total=%0d bad=%0d", total_s, bad_s);
        $finish;
    end

endmodule
